// File: rtl/shift_pkg.sv
// Shared types for the execute-stage shift unit.
// Rotate support for ops 6/7 is enabled by defining SHIFT_ROTATE_EN.
package shift_pkg;

    typedef enum logic [2:0] {
        SH_SLL   = 3'd0,
        SH_SRL   = 3'd1,
        SH_SRA   = 3'd2,
        SH_SLLV  = 3'd3,
        SH_SRLV  = 3'd4,
        SH_SRAV  = 3'd5,
        SH_ROTR  = 3'd6,
        SH_ROTRV = 3'd7
    } shop_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    function automatic logic is_var_op(input shop_t op);
        logic v;
        v = 1'b0;
        unique case (op)
            SH_SLLV, SH_SRLV, SH_SRAV, SH_ROTRV: v = 1'b1;
            default:                             v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/shift_rot_core.sv
// Combinational shifter: SLL/SRL/SRA, plus rotate-right when SHIFT_ROTATE_EN
// is defined (otherwise ops 6/7 decode as logical right shifts).
module shift_rot_core
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0]  in_val,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  shop_t                  op,
    output logic [DATA_WIDTH-1:0]  out_val
);

    logic [DATA_WIDTH-1:0] sll_v;
    logic [DATA_WIDTH-1:0] srl_v;
    logic [DATA_WIDTH-1:0] sra_v;
    logic [DATA_WIDTH-1:0] rot_v;

    assign sll_v = in_val << shamt;
    assign srl_v = in_val >> shamt;
    assign sra_v = DATA_WIDTH'($signed(in_val) >>> shamt);

`ifdef SHIFT_ROTATE_EN
    // Shifting the doubled word wraps the low bits back into the top.
    assign rot_v = DATA_WIDTH'({in_val, in_val} >> shamt);
`else
    assign rot_v = srl_v;
`endif

    always_comb begin
        out_val = srl_v;
        unique case (op)
            SH_SLL, SH_SLLV:   out_val = sll_v;
            SH_SRL, SH_SRLV:   out_val = srl_v;
            SH_SRA, SH_SRAV:   out_val = sra_v;
            SH_ROTR, SH_ROTRV: out_val = rot_v;
            default:           out_val = srl_v;
        endcase
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Execute-stage shift unit with OUT + SKID registers; in_ready is registered.
// Define SHIFT_ROTATE_EN to make ops 6/7 rotate right.
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int TAG_WIDTH   = 5
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [DATA_WIDTH-1:0]  in_rs,
    input  logic [DATA_WIDTH-1:0]  in_rt,
    input  logic [SHAMT_WIDTH-1:0] in_shamt,
    input  logic [TAG_WIDTH-1:0]   in_dest,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_result,
    output logic [TAG_WIDTH-1:0]   out_dest
);

    shop_t                  op;
    logic [SHAMT_WIDTH-1:0] amt;
    logic [DATA_WIDTH-1:0]  res;
    logic                   unused_rs_hi;

    assign op           = shop_t'(in_op);
    assign amt          = is_var_op(op) ? in_rs[SHAMT_WIDTH-1:0] : in_shamt;
    assign unused_rs_hi = ^in_rs[DATA_WIDTH-1:SHAMT_WIDTH];

    shift_rot_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_WIDTH(SHAMT_WIDTH)
    ) u_core (
        .in_val (in_rt),
        .shamt  (amt),
        .op     (op),
        .out_val(res)
    );

    occ_t                  occ_q, occ_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_WIDTH-1:0]  out_dest_q, out_dest_d;
    logic [DATA_WIDTH-1:0] skid_result_q, skid_result_d;
    logic [TAG_WIDTH-1:0]  skid_dest_q, skid_dest_d;
    logic                  accept;
    logic                  drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        occ_d         = occ_q;
        out_result_d  = out_result_q;
        out_dest_d    = out_dest_q;
        skid_result_d = skid_result_q;
        skid_dest_d   = skid_dest_q;
        if (flush) begin
            occ_d         = EMPTY;
            skid_result_d = '0;
            skid_dest_d   = '0;
        end else begin
            unique case (occ_q)
                EMPTY: begin
                    if (accept) begin
                        occ_d        = ONE;
                        out_result_d = res;
                        out_dest_d   = in_dest;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        out_result_d = res;
                        out_dest_d   = in_dest;
                    end else if (accept) begin
                        occ_d         = TWO;
                        skid_result_d = res;
                        skid_dest_d   = in_dest;
                    end else if (drain) begin
                        occ_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        occ_d         = ONE;
                        out_result_d  = skid_result_q;
                        out_dest_d    = skid_dest_q;
                        skid_result_d = '0;
                        skid_dest_d   = '0;
                    end
                end
                default: occ_d = EMPTY;
            endcase
        end
        out_valid_d = (occ_d != EMPTY);
        in_ready_d  = (occ_d != TWO);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q         <= EMPTY;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_dest_q    <= '0;
            skid_result_q <= '0;
            skid_dest_q   <= '0;
        end else begin
            occ_q         <= occ_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_dest_q    <= out_dest_d;
            skid_result_q <= skid_result_d;
            skid_dest_q   <= skid_dest_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_dest   = out_dest_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage: shifts, rotate, skid backpressure,
// flush and asynchronous reset.
module tb_shift_exec_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_shamt;
    logic [4:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    shift_exec_stage dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_shamt  (in_shamt),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_dest  (out_dest)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] sh,
                         input logic [4:0] dst);
        in_valid = 1'b1;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_shamt = sh;
        in_dest  = dst;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    logic [31:0] rot_exp;

    initial begin
`ifdef SHIFT_ROTATE_EN
        rot_exp = 32'h7812_3456;
`else
        rot_exp = 32'h0012_3456;
`endif
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        issue(3'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        idle();
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_dest", 32'(out_dest), 32'd0);
        reset_n = 1'b1;
        step();

        // SLL by 31
        issue(3'd0, 32'h0, 32'h0000_0001, 5'd31, 5'd3);
        step();
        chk("sll_valid", 32'(out_valid), 32'd1);
        chk("sll_result", out_result, 32'h8000_0000);
        chk("sll_dest", 32'(out_dest), 32'd3);

        // SRAV then SRLV back to back, amount from rs
        issue(3'd5, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0, 5'd4);
        step();
        chk("srav_result", out_result, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0, 5'd5);
        step();
        chk("srlv_result", out_result, 32'h0000_0001);
        chk("srlv_dest", 32'(out_dest), 32'd5);
        issue(3'd2, 32'h0, 32'h8000_0001, 5'd0, 5'd6);
        step();
        chk("sra0_result", out_result, 32'h8000_0001);
        issue(3'd3, 32'hFFFF_FFE4, 32'h0000_000F, 5'd0, 5'd7);
        step();
        chk("sllv_result", out_result, 32'h0000_00F0);

        // rotate ops
        issue(3'd6, 32'h0, 32'h1234_5678, 5'd8, 5'd8);
        step();
        chk("rotr_result", out_result, rot_exp);
        issue(3'd7, 32'h0000_0020, 32'h1234_5678, 5'd9, 5'd9);
        step();
        chk("rotrv0_result", out_result, 32'h1234_5678);
        idle();
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // backpressure through the skid register
        out_ready = 1'b0;
        issue(3'd0, 32'h0, 32'h1, 5'd1, 5'd1);
        step();
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        issue(3'd0, 32'h0, 32'h1, 5'd2, 5'd2);
        step();
        chk("bp_ready_two", 32'(in_ready), 32'd0);
        issue(3'd0, 32'h0, 32'h1, 5'd3, 5'd12);
        step();
        chk("bp_stall_res", out_result, 32'h2);
        chk("bp_stall_dest", 32'(out_dest), 32'd1);
        chk("bp_stall_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_b_res", out_result, 32'h4);
        chk("bp_b_dest", 32'(out_dest), 32'd2);
        chk("bp_b_rdy", 32'(in_ready), 32'd1);
        step();
        chk("bp_c_res", out_result, 32'h8);
        chk("bp_c_dest", 32'(out_dest), 32'd12);
        idle();
        step();
        chk("bp_done", 32'(out_valid), 32'd0);

        // flush in TWO with a same-cycle input
        out_ready = 1'b0;
        issue(3'd1, 32'h0, 32'h100, 5'd4, 5'd6);
        step();
        issue(3'd1, 32'h0, 32'h200, 5'd4, 5'd7);
        step();
        chk("fl_two", 32'(in_ready), 32'd0);
        flush = 1'b1;
        issue(3'd0, 32'h0, 32'h1, 5'd0, 5'd9);
        step();
        flush = 1'b0;
        idle();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl_no_ghost", 32'(out_valid), 32'd0);
        issue(3'd0, 32'h0, 32'h3, 5'd1, 5'd10);
        step();
        chk("fl_next_res", out_result, 32'h6);
        chk("fl_next_dest", 32'(out_dest), 32'd10);
        idle();
        step();

        // asynchronous reset while holding two entries
        out_ready = 1'b0;
        issue(3'd0, 32'h0, 32'h1, 5'd5, 5'd13);
        step();
        issue(3'd0, 32'h0, 32'h1, 5'd6, 5'd14);
        step();
        idle();
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);
        chk("ar_result", out_result, 32'd0);
        #2 reset_n = 1'b1;
        step();
        out_ready = 1'b1;
        issue(3'd2, 32'h0, 32'hF000_0000, 5'd4, 5'd11);
        step();
        idle();
        chk("ar_lat_valid", 32'(out_valid), 32'd1);
        chk("ar_lat_res", out_result, 32'hFF00_0000);
        chk("ar_lat_dest", 32'(out_dest), 32'd11);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
